// File: rtl/wb_stage_pkg.sv
// Shared constants and types for the writeback stage.
// Flag layout per lane is {NV,DZ,OF,UF,NX}.
package wb_stage_pkg;

  localparam int NUM_LANES = 4;
  localparam int FLAG_W    = 5;

  localparam int FLAG_NV = 4;
  localparam int FLAG_DZ = 3;
  localparam int FLAG_OF = 2;
  localparam int FLAG_UF = 1;
  localparam int FLAG_NX = 0;

  localparam logic [31:0] FP_ONE       = 32'h3F80_0000;
  localparam logic [7:0]  EXP_ALL_ONES = 8'hFF;

  typedef enum logic [1:0] {
    SRC_NONE,
    SRC_LD,
    SRC_FIFO,
    SRC_BYP
  } wr_src_e;

endpackage

// File: rtl/wb_sat_lane.sv
// FP32 clamp of one lane to [0.0, 1.0].
// NaN and anything with the sign bit set collapse to +0.
module wb_sat_lane
  import wb_stage_pkg::*;
(
  input  logic        sat,
  input  logic [31:0] x,
  output logic [31:0] y
);

  logic is_nan;

  assign is_nan = (x[30:23] == EXP_ALL_ONES) &&
                  (x[22:0] != '0);

  always_comb begin
    y = x;
    if (sat) begin
      if (is_nan || x[31]) y = '0;
      else if (x >= FP_ONE) y = FP_ONE;
    end
  end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: load returns win the RF port, ALU results
// queue behind them; sticky IEEE flags accrue on ALU commit.
module wb_stage
  import wb_stage_pkg::*;
#(
  parameter int DataWidth    = 32,
  parameter int TotalNumBank = 8,
  parameter int AddrWidth    = 5,
  parameter int FifoDepth    = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           sclr,
  input  logic                           ex_pipe,
  input  logic                           ex_des_sat,
  input  logic [NUM_LANES-1:0]           ex_des_mask,
  input  logic [TotalNumBank-1:0]        ex_writeEn,
  input  logic [AddrWidth-1:0]           ex_writeAddr,
  input  logic [DataWidth-1:0]           ex_res0,
  input  logic [DataWidth-1:0]           ex_res1,
  input  logic [DataWidth-1:0]           ex_res2,
  input  logic [DataWidth-1:0]           ex_res3,
  input  logic [FLAG_W-1:0]              ex_flags0,
  input  logic [FLAG_W-1:0]              ex_flags1,
  input  logic [FLAG_W-1:0]              ex_flags2,
  input  logic [FLAG_W-1:0]              ex_flags3,
  input  logic                           ld_valid,
  input  logic [TotalNumBank-1:0]        ld_writeEn,
  input  logic [AddrWidth-1:0]           ld_writeAddr,
  input  logic [NUM_LANES*DataWidth-1:0] ld_data,
  input  logic [NUM_LANES-1:0]           ld_mask,
  input  logic                           flag_clr,
  output logic                           stall_o,
  output logic [TotalNumBank-1:0]        rf_we,
  output logic [AddrWidth-1:0]           rf_addr,
  output logic [NUM_LANES*DataWidth-1:0] rf_data,
  output logic [NUM_LANES-1:0]           rf_lane_mask,
  output logic [NUM_LANES*FLAG_W-1:0]    flags_sticky,
  output logic                           ovf_err
);

  localparam int LW = NUM_LANES * DataWidth;
  localparam int FW = NUM_LANES * FLAG_W;
  localparam int EW = TotalNumBank + AddrWidth +
                      NUM_LANES + LW + FW;
  localparam int PW = $clog2(FifoDepth);
  localparam int CW = PW + 1;

  localparam logic [CW-1:0] FULL_CNT  = CW'(FifoDepth);
  localparam logic [CW-1:0] STALL_CNT = CW'(FifoDepth - 2);

  localparam int OFS_D = FW;
  localparam int OFS_M = FW + LW;
  localparam int OFS_A = FW + LW + NUM_LANES;
  localparam int OFS_W = FW + LW + NUM_LANES + AddrWidth;

  logic [DataWidth-1:0] res [NUM_LANES];
  logic [LW-1:0]        sat_data;
  logic [FW-1:0]        ex_fl;
  logic [EW-1:0]        ex_ent;

  assign res[0] = ex_res0;
  assign res[1] = ex_res1;
  assign res[2] = ex_res2;
  assign res[3] = ex_res3;
  assign ex_fl  = {ex_flags3, ex_flags2, ex_flags1, ex_flags0};

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_sat
    wb_sat_lane u_sat (
      .sat (ex_des_sat),
      .x   (res[i]),
      .y   (sat_data[i*DataWidth +: DataWidth])
    );
  end

  assign ex_ent = {ex_writeEn, ex_writeAddr,
                   ex_des_mask, sat_data, ex_fl};

  logic [EW-1:0] mem [FifoDepth];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          empty;
  logic          ex_ok;
  logic          enq;
  logic          deq;
  logic          drop;
  logic          do_enq;
  wr_src_e       src;

  assign empty   = (count == '0);
  assign stall_o = (count >= STALL_CNT);
  assign ex_ok   = ex_pipe && (|ex_des_mask) && (|ex_writeEn);

  always_comb begin
    src = SRC_NONE;
    if (ld_valid)              src = SRC_LD;
    else if (!sclr && !empty)  src = SRC_FIFO;
    else if (!sclr && ex_ok)   src = SRC_BYP;
  end

  assign deq    = (src == SRC_FIFO);
  assign enq    = ex_ok && !sclr && (src != SRC_BYP);
  assign drop   = enq && (count == FULL_CNT) && !deq;
  assign do_enq = enq && !drop;

  always_ff @(posedge clk) begin
    if (do_enq) mem[wr_ptr] <= ex_ent;
  end

  always_ff @(posedge clk) begin
    if (rst || sclr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_enq) wr_ptr <= wr_ptr + PW'(1);
      if (deq)    rd_ptr <= rd_ptr + PW'(1);
      if (do_enq && !deq)      count <= count + CW'(1);
      else if (deq && !do_enq) count <= count - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst)       ovf_err <= 1'b0;
    else if (drop) ovf_err <= 1'b1;
  end

  logic [EW-1:0]        alu_ent;
  logic [NUM_LANES-1:0] alu_mask;
  logic [FW-1:0]        alu_flags;
  logic [FW-1:0]        cm_flags;
  logic                 commit;

  assign alu_ent   = (src == SRC_FIFO) ? mem[rd_ptr] : ex_ent;
  assign alu_mask  = alu_ent[OFS_M +: NUM_LANES];
  assign alu_flags = alu_ent[FW-1:0];
  assign commit    = (src == SRC_FIFO) || (src == SRC_BYP);

  always_comb begin
    cm_flags = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (alu_mask[i])
        cm_flags[i*FLAG_W +: FLAG_W] = alu_flags[i*FLAG_W +: FLAG_W];
    end
  end

  // clear and commit together keeps only the committing flags
  always_ff @(posedge clk) begin
    if (rst)           flags_sticky <= '0;
    else if (flag_clr) flags_sticky <= commit ? cm_flags : '0;
    else if (commit)   flags_sticky <= flags_sticky | cm_flags;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rf_we        <= '0;
      rf_addr      <= '0;
      rf_data      <= '0;
      rf_lane_mask <= '0;
    end else begin
      unique case (src)
        SRC_LD: begin
          rf_we        <= ld_writeEn;
          rf_addr      <= ld_writeAddr;
          rf_data      <= ld_data;
          rf_lane_mask <= ld_mask;
        end
        SRC_FIFO, SRC_BYP: begin
          rf_we        <= alu_ent[OFS_W +: TotalNumBank];
          rf_addr      <= alu_ent[OFS_A +: AddrWidth];
          rf_data      <= alu_ent[OFS_D +: LW];
          rf_lane_mask <= alu_mask;
        end
        default: begin
          rf_we        <= '0;
          rf_lane_mask <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_stage.sv
// Bench for wb_stage: saturation vector table, directed
// corner sequences and a random run against a queue model.
module tb_wb_stage;
  localparam int FD = 4;

  logic         clk = 1'b0;
  logic         rst, sclr, ex_pipe, ex_des_sat;
  logic [3:0]   ex_des_mask;
  logic [7:0]   ex_writeEn;
  logic [4:0]   ex_writeAddr;
  logic [31:0]  ex_res [4];
  logic [4:0]   ex_fl [4];
  logic         ld_valid;
  logic [7:0]   ld_writeEn;
  logic [4:0]   ld_writeAddr;
  logic [127:0] ld_data;
  logic [3:0]   ld_mask;
  logic         flag_clr;
  logic         stall_o;
  logic [7:0]   rf_we;
  logic [4:0]   rf_addr;
  logic [127:0] rf_data;
  logic [3:0]   rf_lane_mask;
  logic [19:0]  flags_sticky;
  logic         ovf_err;

  always #5 clk = ~clk;

  wb_stage dut (
    .clk          (clk),
    .rst          (rst),
    .sclr         (sclr),
    .ex_pipe      (ex_pipe),
    .ex_des_sat   (ex_des_sat),
    .ex_des_mask  (ex_des_mask),
    .ex_writeEn   (ex_writeEn),
    .ex_writeAddr (ex_writeAddr),
    .ex_res0      (ex_res[0]),
    .ex_res1      (ex_res[1]),
    .ex_res2      (ex_res[2]),
    .ex_res3      (ex_res[3]),
    .ex_flags0    (ex_fl[0]),
    .ex_flags1    (ex_fl[1]),
    .ex_flags2    (ex_fl[2]),
    .ex_flags3    (ex_fl[3]),
    .ld_valid     (ld_valid),
    .ld_writeEn   (ld_writeEn),
    .ld_writeAddr (ld_writeAddr),
    .ld_data      (ld_data),
    .ld_mask      (ld_mask),
    .flag_clr     (flag_clr),
    .stall_o      (stall_o),
    .rf_we        (rf_we),
    .rf_addr      (rf_addr),
    .rf_data      (rf_data),
    .rf_lane_mask (rf_lane_mask),
    .flags_sticky (flags_sticky),
    .ovf_err      (ovf_err)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(string name, logic [127:0] act,
                     logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [7:0]   we;
    logic [4:0]   addr;
    logic [3:0]   mask;
    logic [127:0] data;
    logic [19:0]  flags;
  } ent_t;

  ent_t         q[$];
  logic [7:0]   m_we;
  logic [4:0]   m_addr;
  logic [127:0] m_data;
  logic [3:0]   m_mask;
  logic [19:0]  m_flags;
  logic         m_ovf;

  function automatic logic [31:0] sat_ref(logic s, logic [31:0] x);
    if (!s) return x;
    if (x[30:23] == 8'hFF && x[22:0] != 0) return 32'h0;
    if (x[31]) return 32'h0;
    if (x >= 32'h3F80_0000) return 32'h3F80_0000;
    return x;
  endfunction

  task automatic m_write(ent_t w);
    m_we = w.we; m_addr = w.addr;
    m_data = w.data; m_mask = w.mask;
  endtask

  task automatic model_step();
    ent_t e, w;
    bit ok, commit;
    if (rst) begin
      q.delete();
      m_we = 0; m_addr = 0; m_data = 0; m_mask = 0;
      m_flags = 0; m_ovf = 0;
      return;
    end
    commit = 0;
    ok = ex_pipe && ex_des_mask != 0 && ex_writeEn != 0;
    e.we = ex_writeEn; e.addr = ex_writeAddr; e.mask = ex_des_mask;
    for (int i = 0; i < 4; i++) begin
      e.data[i*32 +: 32] = sat_ref(ex_des_sat, ex_res[i]);
      e.flags[i*5 +: 5] = ex_fl[i];
    end
    w = e;
    if (ld_valid) begin
      m_we = ld_writeEn; m_addr = ld_writeAddr;
      m_data = ld_data; m_mask = ld_mask;
    end else if (!sclr && q.size() > 0) begin
      w = q.pop_front(); m_write(w); commit = 1;
    end else if (!sclr && ok) begin
      m_write(e); commit = 1; ok = 0;
    end else begin
      m_we = 0; m_mask = 0;
    end
    if (sclr) q.delete();
    else if (ok) begin
      if (q.size() == FD) m_ovf = 1;
      else q.push_back(e);
    end
    if (flag_clr) m_flags = 0;
    if (commit)
      for (int i = 0; i < 4; i++)
        if (w.mask[i]) m_flags[i*5 +: 5] |= w.flags[i*5 +: 5];
  endtask

  task automatic cycle();
    if (!rst) chk("stall_o", stall_o, q.size() >= FD - 2);
    @(posedge clk);
    model_step();
    #1;
    chk("rf_we", rf_we, m_we);
    chk("rf_addr", rf_addr, m_addr);
    chk("rf_data", rf_data, m_data);
    chk("rf_lane_mask", rf_lane_mask, m_mask);
    chk("flags_sticky", flags_sticky, m_flags);
    chk("ovf_err", ovf_err, m_ovf);
  endtask

  task automatic idle_in();
    sclr = 0; ex_pipe = 0; ex_des_sat = 0; ex_des_mask = 0;
    ex_writeEn = 0; ex_writeAddr = 0; ld_valid = 0;
    ld_writeEn = 0; ld_writeAddr = 0; ld_data = 0;
    ld_mask = 0; flag_clr = 0;
    for (int i = 0; i < 4; i++) begin
      ex_res[i] = 0; ex_fl[i] = 0;
    end
  endtask

  task automatic set_ex(logic s, logic [3:0] m,
                        logic [7:0] we, logic [4:0] a);
    ex_pipe = 1; ex_des_sat = s; ex_des_mask = m;
    ex_writeEn = we; ex_writeAddr = a;
    for (int i = 0; i < 4; i++) ex_res[i] = $urandom;
  endtask

  task automatic set_ld(logic [7:0] we, logic [4:0] a);
    ld_valid = 1; ld_writeEn = we; ld_writeAddr = a;
    ld_data = {$urandom, $urandom, $urandom, $urandom};
    ld_mask = 4'hF;
  endtask

  task automatic do_reset();
    idle_in(); rst = 1;
    cycle(); cycle();
    rst = 0;
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h3F80_0000;
      1: return 32'h7F80_0000 | 32'($urandom_range(0, 3));
      2: return 32'h8000_0000 | 32'($urandom);
      3: return $urandom;
      4: return 32'h3F7F_FFFF + 32'($urandom_range(0, 2));
      default: return 32'h3F00_0000 | 32'($urandom_range(0, 255));
    endcase
  endfunction

  typedef struct {
    logic [31:0] x;
    logic [31:0] y;
  } sat_vec_t;

  sat_vec_t     tab [12];
  logic [127:0] exp_d;

  initial begin
    tab[0]  = '{32'hBF80_0000, 32'h0000_0000};
    tab[1]  = '{32'h7FC0_0000, 32'h0000_0000};
    tab[2]  = '{32'h4000_0000, 32'h3F80_0000};
    tab[3]  = '{32'h3F00_0000, 32'h3F00_0000};
    tab[4]  = '{32'h8000_0000, 32'h0000_0000};
    tab[5]  = '{32'hFF80_0000, 32'h0000_0000};
    tab[6]  = '{32'h7F80_0000, 32'h3F80_0000};
    tab[7]  = '{32'h3F80_0000, 32'h3F80_0000};
    tab[8]  = '{32'h3F7F_FFFF, 32'h3F7F_FFFF};
    tab[9]  = '{32'h0000_0000, 32'h0000_0000};
    tab[10] = '{32'h7F80_0001, 32'h0000_0000};
    tab[11] = '{32'h0000_0001, 32'h0000_0001};

    do_reset();
    chk("reset rf_we", rf_we, 8'h00);
    chk("reset flags", flags_sticky, 20'h0);
    chk("reset stall", stall_o, 1'b0);

    // saturation table, one 4-lane beat per group, bypass path
    for (int g = 0; g < 3; g++) begin
      idle_in();
      set_ex(1, 4'hF, 8'h04, 5'd3);
      for (int i = 0; i < 4; i++) begin
        ex_res[i] = tab[g*4+i].x;
        exp_d[i*32 +: 32] = tab[g*4+i].y;
      end
      cycle();
      chk("sat_tab we", rf_we, 8'h04);
      chk("sat_tab addr", rf_addr, 5'd3);
      chk("sat_tab data", rf_data, exp_d);
    end
    idle_in();
    set_ex(0, 4'hF, 8'h01, 5'd7);
    ex_res[1] = 32'hBF80_0000;
    exp_d = {ex_res[3], ex_res[2], ex_res[1], ex_res[0]};
    cycle();
    chk("nosat data", rf_data, exp_d);

    // load priority over two queued ALU beats
    idle_in();
    set_ld(8'h01, 5'd9);
    set_ex(0, 4'hF, 8'h02, 5'd10);
    cycle();
    chk("prio ld0", rf_we, 8'h01);
    set_ex(0, 4'hF, 8'h02, 5'd11);
    cycle();
    chk("prio stall", stall_o, 1'b1);
    ex_pipe = 0;
    cycle();
    chk("prio ld2", rf_addr, 5'd9);
    ld_valid = 0;
    cycle();
    chk("prio A", rf_addr, 5'd10);
    cycle();
    chk("prio B", rf_addr, 5'd11);
    cycle();
    chk("prio idle", rf_we, 8'h00);

    // overflow: five beats into a four-deep buffer
    idle_in();
    set_ld(8'h10, 5'd30);
    for (int k = 0; k < 5; k++) begin
      set_ex(0, 4'hF, 8'h08, 5'(k + 1));
      cycle();
      if (k == 3) chk("ovf pre", ovf_err, 1'b0);
    end
    chk("ovf set", ovf_err, 1'b1);
    idle_in();
    for (int k = 0; k < 4; k++) begin
      cycle();
      chk("ovf drain addr", rf_addr, 5'(k + 1));
      chk("ovf drain we", rf_we, 8'h08);
    end
    cycle();
    chk("ovf drain end", rf_we, 8'h00);
    do_reset();

    // sticky flags with clear on commit cycle
    idle_in(); flag_clr = 1; cycle();
    idle_in();
    set_ex(0, 4'h1, 8'h01, 5'd1);
    ex_fl[0] = 5'h01; ex_fl[1] = 5'h1F;
    ex_fl[2] = 5'h1F; ex_fl[3] = 5'h1F;
    cycle();
    chk("flag first", flags_sticky, 20'h00001);
    ex_fl[0] = 5'h10; flag_clr = 1;
    cycle();
    chk("flag clr+commit", flags_sticky, 20'h00010);

    // no-op beats: zero mask, zero bank select
    idle_in();
    set_ex(0, 4'h0, 8'h01, 5'd2);
    for (int i = 0; i < 4; i++) ex_fl[i] = 5'h1F;
    cycle();
    chk("noop mask we", rf_we, 8'h00);
    chk("noop mask flags", flags_sticky, 20'h00010);
    set_ex(0, 4'hF, 8'h00, 5'd2);
    cycle();
    chk("noop we we", rf_we, 8'h00);
    chk("noop we flags", flags_sticky, 20'h00010);

    // flush with three buffered entries and a concurrent load
    idle_in();
    set_ld(8'h20, 5'd4);
    for (int k = 0; k < 3; k++) begin
      set_ex(0, 4'hF, 8'h40, 5'(k + 12));
      cycle();
    end
    set_ld(8'h80, 5'd20);
    set_ex(0, 4'hF, 8'h40, 5'd15);
    sclr = 1;
    cycle();
    chk("sclr ld we", rf_we, 8'h80);
    chk("sclr ld addr", rf_addr, 5'd20);
    chk("sclr stall", stall_o, 1'b0);
    idle_in();
    for (int k = 0; k < 3; k++) begin
      cycle();
      chk("sclr no alu", rf_we, 8'h00);
    end

    // random traffic against the queue model
    for (int n = 0; n < 800; n++) begin
      rst = ($urandom_range(0, 199) == 0);
      sclr = ($urandom_range(0, 29) == 0);
      flag_clr = ($urandom_range(0, 19) == 0);
      ld_valid = ($urandom_range(0, 9) < 4);
      ld_writeEn = 8'(1 << $urandom_range(0, 7));
      ld_writeAddr = 5'($urandom);
      ld_data = {$urandom, $urandom, $urandom, $urandom};
      ld_mask = 4'($urandom);
      ex_pipe = ($urandom_range(0, 9) < 6);
      ex_des_sat = 1'($urandom_range(0, 1));
      ex_des_mask = ($urandom_range(0, 9) == 0) ? 4'h0 : 4'($urandom);
      ex_writeEn = ($urandom_range(0, 14) == 0) ? 8'h00 :
                   8'(1 << $urandom_range(0, 7));
      ex_writeAddr = 5'($urandom);
      for (int i = 0; i < 4; i++) begin
        ex_res[i] = pick();
        ex_fl[i] = 5'($urandom);
      end
      cycle();
    end
    rst = 0;

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
